// File: rtl/iq_pkg.sv
// Shared types and helpers for the multi-channel I/Q power accumulator.
// Width helpers keep the derived port widths consistent between the top and the bench.
package iq_pkg;

    typedef enum logic [1:0] {IDLE, SQ_I, SQ_Q, OUT} pwr_state_t;

    // Wide enough to hold any accumulator plus any sample without wrapping.
    localparam int SAT_W = 64;

    function automatic int ch_width(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

    function automatic int pwr_width(input int acc_w, input int nc_len);
        return 2 * acc_w + $clog2(nc_len);
    endfunction

    // Adds two sign-extended operands and clamps to a w-bit signed range.
    function automatic logic signed [SAT_W-1:0] sat_add(
        input logic signed [SAT_W-1:0] a,
        input logic signed [SAT_W-1:0] b,
        input int                      w
    );
        logic signed [SAT_W-1:0] sum;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        sum = a + b;
        hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo  = -(64'sd1 <<< (w - 1));
        if (sum > hi) begin
            return hi;
        end
        if (sum < lo) begin
            return lo;
        end
        return sum;
    endfunction

endpackage

// File: rtl/iq_sat_accum.sv
// One channel's saturating coherent I/Q accumulator with snapshot-on-dump
// and a sticky saturation flag cleared when the window's output is taken.
module iq_sat_accum
    import iq_pkg::*;
#(
    parameter int IN_W  = 2,
    parameter int ACC_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic signed [IN_W-1:0]  in_i,
    input  logic signed [IN_W-1:0]  in_q,
    input  logic                    clear,
    input  logic                    snap,
    input  logic                    sat_clear,
    output logic signed [ACC_W-1:0] hold_i,
    output logic signed [ACC_W-1:0] hold_q,
    output logic                    sat
);

    logic signed [IN_W-1:0]  sample [2];
    logic signed [ACC_W-1:0] hold   [2];
    logic [1:0]              clip;
    logic                    sat_reg;

    assign sample[0] = in_i;
    assign sample[1] = in_q;

    // Lane 0 is I, lane 1 is Q; both lanes behave identically.
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        logic signed [ACC_W-1:0] acc_reg;
        logic signed [ACC_W-1:0] hold_reg;
        logic signed [ACC_W-1:0] acc_next;
        logic signed [SAT_W-1:0] raw_sum;
        logic signed [SAT_W-1:0] clamped;

        assign raw_sum   = SAT_W'(acc_reg) + SAT_W'(sample[gi]);
        assign clamped   = sat_add(SAT_W'(acc_reg), SAT_W'(sample[gi]), ACC_W);
        assign clip[gi]  = in_valid && (clamped != raw_sum);
        assign acc_next  = in_valid ? clamped[ACC_W-1:0] : acc_reg;
        assign hold[gi]  = hold_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc_reg  <= '0;
                hold_reg <= '0;
            end else begin
                // A sample arriving with the dump belongs to the closing period.
                acc_reg <= clear ? '0 : acc_next;
                if (snap) begin
                    hold_reg <= acc_next;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_reg <= 1'b0;
        end else begin
            sat_reg <= (sat_reg & ~sat_clear) | (|clip);
        end
    end

    assign hold_i = hold[0];
    assign hold_q = hold[1];
    assign sat    = sat_reg;

endmodule

// File: rtl/iq_power_accum.sv
// Multi-channel coherent I/Q accumulation with a time-shared squarer,
// non-coherent power summation and a one-channel-per-beat valid/ready output.
module iq_power_accum
    import iq_pkg::*;
#(
    parameter  int N_CH   = 4,
    parameter  int IN_W   = 2,
    parameter  int ACC_W  = 16,
    parameter  int NC_LEN = 4,
    localparam int CH_W   = ch_width(N_CH),
    localparam int P_W    = pwr_width(ACC_W, NC_LEN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [N_CH*IN_W-1:0]    in_i,
    input  logic [N_CH*IN_W-1:0]    in_q,
    input  logic                    dump,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CH_W-1:0]         out_ch,
    output logic signed [ACC_W-1:0] out_i,
    output logic signed [ACC_W-1:0] out_q,
    output logic [P_W-1:0]          out_power,
    output logic                    out_sat,
    output logic                    busy,
    output logic                    dump_miss
);

    localparam int NCC_W = (NC_LEN > 1) ? $clog2(NC_LEN) : 1;
    localparam int SQ_W  = 2 * ACC_W;
    localparam logic [NCC_W-1:0] NC_LAST = NCC_W'(NC_LEN - 1);
    localparam logic [CH_W-1:0]  CH_LAST = CH_W'(N_CH - 1);

    pwr_state_t              state_reg;
    logic [CH_W-1:0]         ch_reg;
    logic [SQ_W-1:0]         sq_reg;
    logic [NCC_W-1:0]        nc_cnt_reg;
    logic [P_W-1:0]          nc_acc_reg [N_CH];
    logic                    out_valid_reg;
    logic [CH_W-1:0]         out_ch_reg;
    logic signed [ACC_W-1:0] out_i_reg;
    logic signed [ACC_W-1:0] out_q_reg;
    logic [P_W-1:0]          out_power_reg;
    logic                    out_sat_reg;
    logic                    dump_miss_reg;

    logic signed [ACC_W-1:0] hold_i [N_CH];
    logic signed [ACC_W-1:0] hold_q [N_CH];
    logic [N_CH-1:0]         sat_vec;
    logic [N_CH-1:0]         sat_clr;
    logic                    dump_ok;

    assign dump_ok = dump && (state_reg == IDLE);

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        assign sat_clr[gi] = (state_reg == OUT) && out_ready && (ch_reg == CH_W'(gi));

        iq_sat_accum #(
            .IN_W  (IN_W),
            .ACC_W (ACC_W)
        ) u_acc (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_i      (in_i[gi*IN_W +: IN_W]),
            .in_q      (in_q[gi*IN_W +: IN_W]),
            .clear     (dump),
            .snap      (dump_ok),
            .sat_clear (sat_clr[gi]),
            .hold_i    (hold_i[gi]),
            .hold_q    (hold_q[gi]),
            .sat       (sat_vec[gi])
        );
    end

    // Single squarer: I in SQ_I, Q in SQ_Q. Squaring the magnitude keeps
    // the most negative value exact (its magnitude fits as unsigned).
    logic signed [ACC_W-1:0] sq_sel;
    logic [ACC_W-1:0]        sq_mag;
    logic [SQ_W-1:0]         sq_val;
    logic [P_W-1:0]          pwr_sum;
    logic                    is_final;
    logic                    last_ch;

    always_comb begin
        sq_sel = hold_i[ch_reg];
        if (state_reg == SQ_Q) begin
            sq_sel = hold_q[ch_reg];
        end
    end

    assign sq_mag   = sq_sel[ACC_W-1] ? ACC_W'(-sq_sel) : ACC_W'(sq_sel);
    assign sq_val   = SQ_W'(sq_mag) * SQ_W'(sq_mag);
    assign pwr_sum  = nc_acc_reg[ch_reg] + P_W'(sq_reg) + P_W'(sq_val);
    assign is_final = (nc_cnt_reg == NC_LAST);
    assign last_ch  = (ch_reg == CH_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            ch_reg        <= '0;
            sq_reg        <= '0;
            nc_cnt_reg    <= '0;
            for (int c = 0; c < N_CH; c++) begin
                nc_acc_reg[c] <= '0;
            end
            out_valid_reg <= 1'b0;
            out_ch_reg    <= '0;
            out_i_reg     <= '0;
            out_q_reg     <= '0;
            out_power_reg <= '0;
            out_sat_reg   <= 1'b0;
            dump_miss_reg <= 1'b0;
        end else begin
            dump_miss_reg <= dump && (state_reg != IDLE);
            case (state_reg)
                IDLE: begin
                    if (dump) begin
                        ch_reg    <= '0;
                        state_reg <= SQ_I;
                    end
                end
                SQ_I: begin
                    sq_reg    <= sq_val;
                    state_reg <= SQ_Q;
                end
                SQ_Q: begin
                    nc_acc_reg[ch_reg] <= pwr_sum;
                    if (is_final) begin
                        // Output registers are loaded once and held through any stall.
                        out_valid_reg <= 1'b1;
                        out_ch_reg    <= ch_reg;
                        out_i_reg     <= hold_i[ch_reg];
                        out_q_reg     <= hold_q[ch_reg];
                        out_power_reg <= pwr_sum;
                        out_sat_reg   <= sat_vec[ch_reg];
                        state_reg     <= OUT;
                    end else if (last_ch) begin
                        nc_cnt_reg <= nc_cnt_reg + 1'b1;
                        state_reg  <= IDLE;
                    end else begin
                        ch_reg    <= ch_reg + 1'b1;
                        state_reg <= SQ_I;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_reg      <= 1'b0;
                        nc_acc_reg[ch_reg] <= '0;
                        if (last_ch) begin
                            nc_cnt_reg <= '0;
                            state_reg  <= IDLE;
                        end else begin
                            ch_reg    <= ch_reg + 1'b1;
                            state_reg <= SQ_I;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_reg;
    assign out_ch    = out_ch_reg;
    assign out_i     = out_i_reg;
    assign out_q     = out_q_reg;
    assign out_power = out_power_reg;
    assign out_sat   = out_sat_reg;
    assign busy      = (state_reg != IDLE);
    assign dump_miss = dump_miss_reg;

endmodule

// File: tb/tb_iq_power_accum.sv
// Directed bench for iq_power_accum: N_CH=2, IN_W=4, ACC_W=8, NC_LEN=4.
// Expected values are hand-computed per window and listed at each call site.
module tb_iq_power_accum;

    localparam int N_CH   = 2;
    localparam int IN_W   = 4;
    localparam int ACC_W  = 8;
    localparam int NC_LEN = 4;
    localparam int CH_W   = 1;
    localparam int P_W    = 2 * ACC_W + 2;

    logic                    clk;
    logic                    rst_n;
    logic                    in_valid;
    logic [N_CH*IN_W-1:0]    in_i;
    logic [N_CH*IN_W-1:0]    in_q;
    logic                    dump;
    logic                    out_valid;
    logic                    out_ready;
    logic [CH_W-1:0]         out_ch;
    logic signed [ACC_W-1:0] out_i;
    logic signed [ACC_W-1:0] out_q;
    logic [P_W-1:0]          out_power;
    logic                    out_sat;
    logic                    busy;
    logic                    dump_miss;

    int total = 0;
    int bad   = 0;

    iq_power_accum #(
        .N_CH   (N_CH),
        .IN_W   (IN_W),
        .ACC_W  (ACC_W),
        .NC_LEN (NC_LEN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_i      (in_i),
        .in_q      (in_q),
        .dump      (dump),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_i     (out_i),
        .out_q     (out_q),
        .out_power (out_power),
        .out_sat   (out_sat),
        .busy      (busy),
        .dump_miss (dump_miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", tag, $signed(got), $signed(exp));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int i0, input int q0, input int i1, input int q1);
        in_i = {4'(i1), 4'(i0)};
        in_q = {4'(q1), 4'(q0)};
    endtask

    // n samples per channel; with_dump puts the last sample in the dump cycle.
    task automatic period(input int i0, input int q0, input int i1, input int q1,
                          input int n, input bit with_dump);
        set_in(i0, q0, i1, q1);
        in_valid = 1'b1;
        repeat (n - int'(with_dump)) step();
        in_valid = with_dump;
        dump     = 1'b1;
        step();
        dump     = 1'b0;
        in_valid = 1'b0;
    endtask

    // Non-final period: engine busy exactly 2*N_CH cycles, no output beat.
    task automatic nonfinal(input string tag, input int i0, input int q0,
                            input int i1, input int q1, input int n, input bit with_dump);
        int busy_cnt = 0;
        int vld_cnt  = 0;
        period(i0, q0, i1, q1, n, with_dump);
        for (int k = 0; k < 6; k++) begin
            busy_cnt += int'(busy);
            vld_cnt  += int'(out_valid);
            step();
        end
        chk({tag, "_busy"}, busy_cnt, 2 * N_CH);
        chk({tag, "_novalid"}, vld_cnt, 0);
    endtask

    task automatic expect_beat(input string tag, input int ch, input int i, input int q,
                               input int p, input int sat);
        int waited = 0;
        while (out_valid !== 1'b1 && waited < 12) begin
            step();
            waited++;
        end
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_ch"}, out_ch, ch);
        chk({tag, "_i"}, 64'($signed(out_i)), i);
        chk({tag, "_q"}, 64'($signed(out_q)), q);
        chk({tag, "_power"}, out_power, p);
        chk({tag, "_sat"}, out_sat, sat);
        $display("beat %s: ch=%0d i=%0d q=%0d power=%0d sat=%0d",
                 tag, out_ch, out_i, out_q, out_power, out_sat);
    endtask

    task automatic settle(input string tag);
        repeat (3) step();
        chk({tag, "_idle"}, busy, 0);
    endtask

    task automatic quiet(input string tag);
        int vld_cnt = 0;
        repeat (5) begin
            step();
            vld_cnt += int'(out_valid);
        end
        chk({tag, "_novalid"}, vld_cnt, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_i      = '0;
        in_q      = '0;
        dump      = 1'b0;
        out_ready = 1'b1;

        // Reset held with random activity on the inputs.
        repeat (5) begin
            in_valid = 1'($urandom);
            in_i     = 8'($urandom);
            in_q     = 8'($urandom);
            dump     = 1'($urandom);
            step();
        end
        chk("rst_valid", out_valid, 0);
        chk("rst_ch", out_ch, 0);
        chk("rst_i", out_i, 0);
        chk("rst_q", out_q, 0);
        chk("rst_power", out_power, 0);
        chk("rst_sat", out_sat, 0);
        chk("rst_busy", busy, 0);
        chk("rst_miss", dump_miss, 0);
        in_valid = 1'b0;
        in_i     = '0;
        in_q     = '0;
        dump     = 1'b0;
        rst_n    = 1'b1;
        quiet("post_rst");

        // Window 1: 10 samples per period, ch0 (1,-1), ch1 (2,3); latency check.
        nonfinal("w1p1", 1, -1, 2, 3, 10, 1'b0);
        nonfinal("w1p2", 1, -1, 2, 3, 10, 1'b0);
        nonfinal("w1p3", 1, -1, 2, 3, 10, 1'b0);
        period(1, -1, 2, 3, 10, 1'b0);
        chk("w1_lat_t0", out_valid, 0);
        step();
        chk("w1_lat_t1", out_valid, 0);
        step();
        expect_beat("w1_ch0", 0, 10, -10, 800, 0);
        step();
        chk("w1_gap", out_valid, 0);
        step();
        step();
        expect_beat("w1_ch1", 1, 20, 30, 5200, 0);
        step();
        chk("w1_free", busy, 0);

        // Window 2: one sample per period, taken in the dump cycle; stalled output.
        nonfinal("w2p1", 3, 4, -2, 0, 1, 1'b1);
        nonfinal("w2p2", 3, 4, -2, 0, 1, 1'b1);
        nonfinal("w2p3", 3, 4, -2, 0, 1, 1'b1);
        out_ready = 1'b0;
        period(3, 4, -2, 0, 1, 1'b1);
        step();
        step();
        expect_beat("w2_ch0", 0, 3, 4, 100, 0);
        for (int k = 0; k < 5; k++) begin
            set_in(1, 0, 0, 0);
            in_valid = (k < 2);
            dump     = (k == 2);
            step();
            dump     = 1'b0;
            in_valid = 1'b0;
            chk($sformatf("w2_stall%0d", k),
                {out_valid, out_ch, out_i, out_q, out_power},
                {1'b1, 1'b0, 8'sd3, 8'sd4, 18'd100});
            if (k == 2) chk("w2_miss_pulse", dump_miss, 1);
            if (k == 3) chk("w2_miss_end", dump_miss, 0);
        end
        out_ready = 1'b1;
        step();
        expect_beat("w2_ch1", 1, -2, 0, 16, 0);
        settle("w2");

        // Window 3: the missed dump must not have advanced the period count.
        nonfinal("w3p1", 1, 1, 1, -2, 1, 1'b1);
        nonfinal("w3p2", 1, 1, 1, -2, 1, 1'b1);
        nonfinal("w3p3", 1, 1, 1, -2, 1, 1'b1);
        period(1, 1, 1, -2, 1, 1'b1);
        expect_beat("w3_ch0", 0, 1, 1, 8, 0);
        step();
        expect_beat("w3_ch1", 1, 1, -2, 20, 0);
        settle("w3");

        // Window 4: clamp to +127 and to -128 in the last period.
        nonfinal("w4p1", 0, 0, 0, 0, 1, 1'b1);
        nonfinal("w4p2", 0, 0, 0, 0, 1, 1'b1);
        nonfinal("w4p3", 0, 0, 0, 0, 1, 1'b1);
        period(7, 0, -8, -8, 20, 1'b0);
        expect_beat("w4_ch0", 0, 127, 0, 16129, 1);
        step();
        expect_beat("w4_ch1", 1, -128, -128, 32768, 1);
        settle("w4");

        // Window 5: sat has cleared; then reset while stalled in OUT.
        nonfinal("w5p1", 1, 0, 0, 0, 1, 1'b1);
        nonfinal("w5p2", 1, 0, 0, 0, 1, 1'b1);
        nonfinal("w5p3", 1, 0, 0, 0, 1, 1'b1);
        out_ready = 1'b0;
        period(1, 0, 0, 0, 1, 1'b1);
        expect_beat("w5_ch0", 0, 1, 0, 4, 0);
        set_in(5, 5, 5, 5);
        in_valid = 1'b1;
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_busy", busy, 0);
        chk("rst_out_power", out_power, 0);
        chk("rst_out_i", out_i, 0);
        in_valid = 1'b0;
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;

        // Reset while the engine sits in SQ_Q.
        period(1, 1, 1, 1, 1, 1'b1);
        step();
        rst_n = 1'b0;
        #1;
        chk("rst_sqq_busy", busy, 0);
        chk("rst_sqq_valid", out_valid, 0);
        step();
        rst_n = 1'b1;
        quiet("post_rst2");

        // Window 6: only post-reset samples contribute.
        nonfinal("w6p1", 1, 1, 1, 1, 1, 1'b1);
        nonfinal("w6p2", 1, 1, 1, 1, 1, 1'b1);
        nonfinal("w6p3", 1, 1, 1, 1, 1, 1'b1);
        period(1, 1, 1, 1, 1, 1'b1);
        expect_beat("w6_ch0", 0, 1, 1, 8, 0);
        step();
        expect_beat("w6_ch1", 1, 1, 1, 8, 0);
        settle("w6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
